// File: rtl/data_memory_dumper.sv
// Debug-path master that walks every data-memory word and streams it out as 4 bytes, LSB first.
// Latency: 1 + READ_LATENCY + 4 cycles per word with the transmitter always ready, then a 1-cycle DONE.
// Backpressure: in SEND, o_tx_valid/o_tx_data hold until i_tx_ready; no word advances while stalled.
//
// Ports: i_clk/i_reset (async, active-high); i_start dump request (IDLE only);
//        o_r_addr/o_r_en/o_r_addressing/o_r_signing + i_r_data = memory read port (driven only while busy);
//        o_tx_data/o_tx_valid/i_tx_ready = byte stream; o_busy = dump in progress; o_done = completion pulse.
module data_memory_dumper #(
    parameter int NB_DATA_BUS  = 32,
    parameter int N_ADDRESS    = 64,
    parameter int NB_ADDRESS   = $clog2(N_ADDRESS),
    parameter int READ_LATENCY = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    output logic [NB_ADDRESS-1:0]  o_r_addr,
    output logic                   o_r_en,
    output logic [1:0]             o_r_addressing,
    output logic                   o_r_signing,
    input  logic [NB_DATA_BUS-1:0] i_r_data,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int N_WORDS = N_ADDRESS / 4;
    localparam int NB_WORD = $clog2(N_WORDS);
    localparam logic [NB_WORD-1:0] LAST_WORD = NB_WORD'(N_WORDS - 1);
    // Index of the final WAIT cycle; unused when READ_LATENCY is 0 (WAIT is skipped).
    localparam logic [1:0] LAST_WAIT = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [NB_WORD-1:0]       word_idx;
    logic [1:0]               byte_idx;
    logic [1:0]               wait_cnt;
    logic [NB_DATA_BUS-1:0]   buffer;

    logic byte_xfer;
    assign byte_xfer = (state == SEND) && i_tx_ready;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (i_start) state_next = READ;
            READ: state_next = (READ_LATENCY == 0) ? SEND : WAIT;
            WAIT: if (wait_cnt == LAST_WAIT) state_next = SEND;
            SEND: begin
                if (byte_xfer && (byte_idx == 2'd3)) begin
                    state_next = (word_idx == LAST_WORD) ? DONE : READ;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Word/byte walk, wait counter and capture buffer
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            word_idx <= '0;
            byte_idx <= '0;
            wait_cnt <= '0;
            buffer   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                end
                READ: begin
                    wait_cnt <= '0;
                    byte_idx <= '0;
                    if (READ_LATENCY == 0) buffer <= i_r_data;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    if (wait_cnt == LAST_WAIT) buffer <= i_r_data;
                end
                SEND: begin
                    if (byte_xfer) begin
                        if (byte_idx == 2'd3) begin
                            byte_idx <= '0;
                            // Last word keeps its index so o_r_addr holds the final address.
                            if (word_idx != LAST_WORD) word_idx <= word_idx + 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    assign o_r_addr       = {word_idx, 2'b00};
    assign o_r_addressing = 2'b11;
    assign o_r_signing    = 1'b0;

    always_comb begin
        o_r_en     = 1'b0;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (state)
            READ, WAIT: begin
                o_r_en = 1'b1;
                o_busy = 1'b1;
            end
            SEND: begin
                o_tx_valid = 1'b1;
                o_tx_data  = buffer[{byte_idx, 3'b000} +: 8];
                o_busy     = 1'b1;
            end
            DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_memory_dumper.sv
// Bench for data_memory_dumper: two instances (1-cycle and 2-cycle read latency) share one memory image.
// Expected byte stream is built directly from the memory contents (16 words, 4 bytes each, LSB first).
// Transmitter readiness is held, randomized or stalled; timing and handshake rules are checked each cycle.
module tb_data_memory_dumper;

    localparam int NW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start        [2];
    logic [5:0]  r_addr       [2];
    logic        r_en         [2];
    logic [1:0]  r_addressing [2];
    logic        r_signing    [2];
    logic [31:0] r_data       [2];
    logic [7:0]  tx_data      [2];
    logic        tx_valid     [2];
    logic        tx_ready     [2];
    logic        busy         [2];
    logic        done         [2];

    logic [31:0] mem [NW];
    logic [31:0] pipe1;

    data_memory_dumper #(.READ_LATENCY(1)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_start(start[0]),
        .o_r_addr(r_addr[0]), .o_r_en(r_en[0]), .o_r_addressing(r_addressing[0]),
        .o_r_signing(r_signing[0]), .i_r_data(r_data[0]),
        .o_tx_data(tx_data[0]), .o_tx_valid(tx_valid[0]), .i_tx_ready(tx_ready[0]),
        .o_busy(busy[0]), .o_done(done[0])
    );

    data_memory_dumper #(.READ_LATENCY(2)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_start(start[1]),
        .o_r_addr(r_addr[1]), .o_r_en(r_en[1]), .o_r_addressing(r_addressing[1]),
        .o_r_signing(r_signing[1]), .i_r_data(r_data[1]),
        .o_tx_data(tx_data[1]), .o_tx_valid(tx_valid[1]), .i_tx_ready(tx_ready[1]),
        .o_busy(busy[1]), .o_done(done[1])
    );

    // Memory with 1-cycle read latency
    always @(posedge clk) begin
        if (r_en[0]) r_data[0] <= mem[r_addr[0][5:2]];
    end

    // Memory with 2-cycle read latency
    always @(posedge clk) begin
        if (r_en[1]) pipe1 <= mem[r_addr[1][5:2]];
        r_data[1] <= pipe1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input int i);
        check("rst_raddr", r_addr[i], 0);
        check("rst_ren", r_en[i], 0);
        check("rst_txdata", tx_data[i], 0);
        check("rst_txvalid", tx_valid[i], 0);
        check("rst_busy", busy[i], 0);
        check("rst_done", done[i], 0);
        check("addressing", r_addressing[i], 2'b11);
        check("signing", r_signing[i], 0);
    endtask

    // mode bit0: random ready, bit1: 5-cycle stall at word 1 byte 2, bit2: stray start pulses.
    // abort_at >= 0: assert reset once that many bytes have been sent, then return.
    task automatic dump(input int i, input int rl, input int mode, input int abort_at);
        logic [7:0] exp_q[$];
        int sent = 0, cyc = 0, done_cnt = 0, done_cyc = -1, en_cnt = 0, stall = 0, post = 0;
        bit stall_used = 0;
        logic pv = 0;
        logic [7:0] pd = 8'h00;

        for (int w = 0; w < NW; w++)
            for (int b = 0; b < 4; b++) exp_q.push_back(mem[w][8*b +: 8]);

        @(negedge clk); start[i] = 1'b1;
        @(negedge clk); start[i] = 1'b0;

        while (post < 4 && cyc < 400) begin
            if (abort_at >= 0 && sent == abort_at && tx_valid[i]) begin
                #1 rst = 1'b1;
                #1 check_reset(i);
                #1 rst = 1'b0;
                tx_ready[i] = 1'b0;
                return;
            end
            if (r_en[i]) begin
                en_cnt++;
                check("raddr", r_addr[i], (sent / 4) * 4);
            end
            if (tx_valid[i]) check("ren_in_send", r_en[i], 0);
            if (pv) begin
                check("hold_vld", tx_valid[i], 1);
                check("hold_dat", tx_data[i], pd);
            end
            if (done[i]) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_busy", busy[i], 1);
            end else if (done_cyc >= 0) begin
                check("idle_after_done", busy[i], 0);
            end
            start[i] = ((mode & 4) != 0) && (done[i] || (sent == 20 && tx_valid[i]));

            if ((mode & 2) != 0 && !stall_used && sent == 6 && tx_valid[i]) begin
                stall = 5;
                stall_used = 1;
            end
            if (stall > 0) begin
                tx_ready[i] = 1'b0;
                stall--;
            end else begin
                tx_ready[i] = ((mode & 1) != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            end

            pv = tx_valid[i] && !tx_ready[i];
            pd = tx_data[i];
            if (tx_valid[i] && tx_ready[i]) begin
                if (sent < exp_q.size()) check("byte", tx_data[i], exp_q[sent]);
                sent++;
            end
            if (done_cyc >= 0) post++;
            @(negedge clk);
            cyc++;
        end
        start[i] = 1'b0;
        tx_ready[i] = 1'b0;
        check("done_count", done_cnt, 1);
        check("byte_count", sent, 4 * NW);
        check("en_cycles", en_cnt, NW * (rl + 1));
        if (mode == 0) check("done_cycle", done_cyc, NW * (5 + rl));
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0;
            tx_ready[k] = 1'b0;
        end
        for (int w = 0; w < NW; w++) mem[w] = w;
        mem[0] = 32'h1122_3344;
        mem[1] = 32'hA5A5_0F0F;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset asserted while idle
        #2 rst = 1'b1;
        #1 check_reset(0);
        check_reset(1);
        #1 rst = 1'b0;
        @(negedge clk);

        dump(0, 1, 0, -1);          // straight dump, ready held
        dump(0, 1, 2, -1);          // stall mid-word
        dump(0, 1, 4, -1);          // stray starts in SEND and DONE
        for (int w = 2; w < NW; w++) mem[w] = $urandom;
        dump(0, 1, 1, -1);          // random backpressure
        dump(0, 1, 0, 29);          // reset during word 7
        dump(0, 1, 0, -1);          // restarts from word 0
        dump(1, 2, 0, -1);          // 2-cycle memory, ready held
        dump(1, 2, 3, -1);          // 2-cycle memory, random ready + stall
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
